// File: rtl/ota_bitstream_decimator.sv
// One-bit OTA comparator stream to 8-bit duty-cycle code over a 2^WINDOW_LOG2 window.
// Optional build macro DOTA_DEGLITCH_EN inserts a 3-tap majority filter after the synchroniser.
//
// state  | meaning
// IDLE   | disabled, counters cleared, code/sat held
// SETTLE | discarding SETTLE_CYCLES samples after enable
// ACCUM  | counting ones; windows close back-to-back
module ota_bitstream_decimator #(
    parameter int WINDOW_LOG2   = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmp_in,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       sat,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } state_t;

    localparam logic [WINDOW_LOG2-1:0] WCNT_LAST   = '1;
    localparam logic [7:0]             SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t                 state;
    logic [1:0]             sync_q;
    logic                   s;
    logic                   b;
    logic [7:0]             settle_cnt;
    logic [WINDOW_LOG2-1:0] wcnt;
    logic [WINDOW_LOG2:0]   ones;
    logic [WINDOW_LOG2:0]   total;
    logic [7:0]             code_next;
    logic                   sat_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], cmp_in};
        end
    end

    assign s = sync_q[1];

`ifdef DOTA_DEGLITCH_EN
    logic [1:0] hist;
    logic       b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b00;
            b_q  <= 1'b0;
        end else begin
            hist <= {hist[0], s};
            b_q  <= (s & hist[0]) | (s & hist[1]) | (hist[0] & hist[1]);
        end
    end

    assign b = b_q;
`else
    assign b = s;
`endif

    // total may reach 2^W only when every sample was one; clip it so the code saturates at 0xFF
    assign total     = ones + {{WINDOW_LOG2{1'b0}}, b};
    assign code_next = total[WINDOW_LOG2] ? 8'hFF : total[WINDOW_LOG2-1 -: 8];
    assign sat_next  = (total == '0) | total[WINDOW_LOG2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            settle_cnt <= '0;
            wcnt       <= '0;
            ones       <= '0;
            code       <= 8'h00;
            sat        <= 1'b0;
            code_valid <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (!ena) begin
                state      <= IDLE;
                busy       <= 1'b0;
                settle_cnt <= '0;
                wcnt       <= '0;
                ones       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= SETTLE;
                        busy       <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                    SETTLE: begin
                        if (settle_cnt == '0) begin
                            state <= ACCUM;
                            wcnt  <= '0;
                            ones  <= '0;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    ACCUM: begin
                        if (wcnt == WCNT_LAST) begin
                            code       <= code_next;
                            sat        <= sat_next;
                            code_valid <= 1'b1;
                            wcnt       <= '0;
                            ones       <= '0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                            ones <= total;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ota_bitstream_decimator.md
# ota_bitstream_decimator

Converts the one-bit comparator output of the digital OTA into a registered 8-bit duty-cycle code. It sits directly downstream of the OTA. The raw `Out` net is asynchronous to `clk`, so the block synchronises it, optionally deglitches it, and counts ones over a fixed power-of-two window. At the end of each window it publishes the result as a one-cycle `code_valid` strobe, together with a saturation flag.

## Interface
- `WINDOW_LOG2`, default 8: window length is 2^WINDOW_LOG2 clk cycles; legal range 8..12.
- `SETTLE_CYCLES`, default 16: samples discarded after enable, before the first window; legal range 1..255.

- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: block enable; low forces IDLE.
- `cmp_in` in 1: raw OTA comparator output, asynchronous to `clk`.
- `code` out 8: duty-cycle code of the last completed window.
- `code_valid` out 1: one-cycle strobe when `code` updates.
- `sat` out 1: last window was all ones or all zeros.
- `busy` out 1: high in SETTLE or ACCUM.

## Operation
- Input path: 2-flop synchroniser on `cmp_in` produces `s`. With `DOTA_DEGLITCH_EN` defined, `s` then feeds a filter (see Configuration). The resulting sample bit is `b`.
- State machine has three states:
  - IDLE: `busy`=0. Goes to SETTLE on the first cycle `ena`=1.
  - SETTLE: counts `SETTLE_CYCLES` samples, with `b` ignored. Goes to ACCUM after the last one.
  - ACCUM: window counter `wcnt` (WINDOW_LOG2 bits) runs 0..2^W−1 and ones counter `ones` (W+1 bits) adds `b` each cycle. In the cycle where `wcnt`=2^W−1, that sample is included and the window closes:
    - `code` and `sat` load;
    - `wcnt` and `ones` clear;
    - state stays ACCUM, so windows run back-to-back with no gap.
- Code arithmetic:
  - `total` = final ones count, range 0..2^W.
  - `clip` = min(`total`, 2^W−1), i.e. saturating.
  - `code` = `clip`[W−1:W−8], the top 8 bits.
  - `sat` = 1 iff `total`==0 or `total`==2^W.
- `ena` falling in any state: go to IDLE on the next edge and clear `wcnt`, `ones` and the settle counter. A partial window is discarded with no `code_valid`. `code` and `sat` hold.
- `ena` re-asserted: always restarts from SETTLE.
- Reset values: `code`=0x00, `code_valid`=0, `sat`=0, `busy`=0, state IDLE, all counters 0, synchroniser and filter flops 0.

## Timing
- `cmp_in` to `b` latency: 2 cycles, or 3 with the deglitch filter.
- First `code_valid` comes `SETTLE_CYCLES` + 2^W cycles after the first `ena`=1 edge. After that it repeats every 2^W cycles exactly.
- `code_valid` is high for the single cycle after the window-closing edge, aligned with the new `code`/`sat` values.
- `rst_n` asserted mid-window: all state clears immediately (asynchronous). Deassertion is synchronised externally by the top level.
- `ena` and the window close in the same cycle: `ena`=0 wins. No update, no strobe.

## Configuration
- Macro: `DOTA_DEGLITCH_EN`.
- Defined: a 3-tap majority filter over the last three synchronised samples drives `b`. It adds 1 cycle of latency and removes isolated single-cycle pulses.
- Undefined: `b` = `s` directly, with no filter flops.
- Window arithmetic and the state machine are identical either way.

## Test plan
- `cmp_in`=1 constant, W=8, `ena`=1: `code_valid` every 256 cycles after settle, `code`=0xFF, `sat`=1.
- `cmp_in`=0 constant: `code`=0x00, `sat`=1.
- Square wave with period 4 cycles, 50% duty, W=8: `total`=128, `code`=0x80, `sat`=0. With W=10: `code`=0x80, strobe every 1024 cycles.
- `ena` dropped at `wcnt`=100 after one completed window: no `code_valid`, `code` holds its previous value, `busy`=0 next cycle. Re-assert: next strobe comes 16+256 cycles later.
- `rst_n` pulsed low mid-window: all outputs 0 immediately. Restart gives first strobe at `SETTLE_CYCLES`+2^W.
- Zero stream with isolated 1-cycle high pulses every 8 cycles:
  - with `DOTA_DEGLITCH_EN`: `code`=0x00, `sat`=1;
  - without it: `code`=0x20 (32 ones), `sat`=0.
